data_mem_arbiter: RTL and testbench

//  Two-port arbiter/sequencer for the single-ported 16-word data memory. Port 0 is the

---
 rtl/data_mem_arbiter.sv | 114 +++++++++++
 tb/tb_data_mem_arbiter.sv | 406 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_arbiter.sv
// Round-robin arbiter/sequencer that shares the single-ported 16-word data memory
// between the load/store stage (port 0) and the debug/DMA loader (port 1).
module data_mem_arbiter #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 4,
    parameter int MEM_LAT = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req0,
    input  logic              we0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [DATA_W-1:0] wdata0,
    output logic              ack0,
    output logic [DATA_W-1:0] rdata0,
    input  logic              req1,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata1,
    output logic              ack1,
    output logic [DATA_W-1:0] rdata1,
    output logic              MemRead,
    output logic              MemWrite,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ACCESS = 2'd1;
    localparam logic [1:0] RESP   = 2'd2;

    localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

    logic [1:0]        state;
    logic [CNT_W-1:0]  cnt;
    logic              last_grant;
    logic              sel;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              grant;
    logic              in_access;

    // On a tie the port that was not served last wins; otherwise whoever asks.
    always_comb begin
        grant = req1;
        if (req0 && req1) begin
            grant = ~last_grant;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= '0;
            last_grant <= 1'b1;
            sel        <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            rdata0     <= '0;
            rdata1     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req0 || req1) begin
                        sel        <= grant;
                        last_grant <= grant;
                        we_q       <= grant ? we1 : we0;
                        addr_q     <= grant ? addr1 : addr0;
                        wdata_q    <= grant ? wdata1 : wdata0;
                        cnt        <= CNT_W'(MEM_LAT - 1);
                        state      <= ACCESS;
                    end
                end
                ACCESS: begin
                    // Read data is only guaranteed on the last strobe cycle.
                    if (cnt != '0) begin
                        cnt <= cnt - CNT_W'(1);
                    end else begin
                        if (!we_q) begin
                            if (sel) begin
                                rdata1 <= mem_rdata;
                            end else begin
                                rdata0 <= mem_rdata;
                            end
                        end
                        state <= RESP;
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Memory-side signals decode from state and latched regs only, so an async
    // reset drops the strobes immediately and requests never reach them directly.
    assign in_access = (state == ACCESS);
    assign MemRead   = in_access & ~we_q;
    assign MemWrite  = in_access & we_q;
    assign mem_addr  = in_access ? addr_q : '0;
    assign mem_wdata = in_access ? wdata_q : '0;
    assign ack0      = (state == RESP) & ~sel;
    assign ack1      = (state == RESP) & sel;
    assign busy      = (state != IDLE);

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Randomized bench for data_mem_arbiter: a transaction-level model predicts grant
// order, ack timing, memory contents and read data for MEM_LAT=1 and MEM_LAT=3 instances.
module tb_data_mem_arbiter;

    logic        clock = 1'b0;
    logic        reset = 1'b1;

    logic        req0 = 1'b0, we0 = 1'b0, req1 = 1'b0, we1 = 1'b0;
    logic [3:0]  addr0 = '0, addr1 = '0;
    logic [31:0] wdata0 = '0, wdata1 = '0;
    logic        ack0, ack1, MemRead, MemWrite, busy;
    logic [31:0] rdata0, rdata1, mem_wdata, mem_rdata;
    logic [3:0]  mem_addr;

    logic        req0_l3 = 1'b0, we0_l3 = 1'b0, req1_l3 = 1'b0, we1_l3 = 1'b0;
    logic [3:0]  addr0_l3 = '0, addr1_l3 = '0;
    logic [31:0] wdata0_l3 = '0, wdata1_l3 = '0, mem_rdata_l3 = '0;
    logic        ack0_l3, ack1_l3, mem_read_l3, mem_write_l3, busy_l3;
    logic [31:0] rdata0_l3, rdata1_l3, mem_wdata_l3;
    logic [3:0]  mem_addr_l3;

    logic [31:0] mem_model [16];
    logic        fill_en = 1'b0;
    logic [3:0]  fill_idx = '0;
    logic [31:0] fill_val = '0;

    logic [31:0] ref_mem [16];
    logic [31:0] ref_rd0, ref_rd1;
    logic        ref_last;

    int n_vec = 0;
    int n_err = 0;

    data_mem_arbiter #(.DATA_W(32), .ADDR_W(4), .MEM_LAT(1)) dut (
        .clock(clock), .reset(reset),
        .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .ack0(ack0), .rdata0(rdata0),
        .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .ack1(ack1), .rdata1(rdata1),
        .MemRead(MemRead), .MemWrite(MemWrite), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
    );

    data_mem_arbiter #(.DATA_W(32), .ADDR_W(4), .MEM_LAT(3)) dut_l3 (
        .clock(clock), .reset(reset),
        .req0(req0_l3), .we0(we0_l3), .addr0(addr0_l3), .wdata0(wdata0_l3), .ack0(ack0_l3), .rdata0(rdata0_l3),
        .req1(req1_l3), .we1(we1_l3), .addr1(addr1_l3), .wdata1(wdata1_l3), .ack1(ack1_l3), .rdata1(rdata1_l3),
        .MemRead(mem_read_l3), .MemWrite(mem_write_l3), .mem_addr(mem_addr_l3),
        .mem_wdata(mem_wdata_l3), .mem_rdata(mem_rdata_l3), .busy(busy_l3)
    );

    always #5 clock = ~clock;

    // Single-ported memory seen by the MEM_LAT=1 instance, preloaded during reset.
    always @(posedge clock) begin
        if (fill_en) begin
            mem_model[fill_idx] <= fill_val;
        end else if (MemWrite) begin
            mem_model[mem_addr] <= mem_wdata;
        end
    end
    assign mem_rdata = mem_model[mem_addr];

    task automatic fill_mem();
        for (int i = 0; i < 16; i++) begin
            fill_en  = 1'b1;
            fill_idx = 4'(i);
            fill_val = $urandom;
            ref_mem[i] = fill_val;
            @(negedge clock);
        end
        fill_en = 1'b0;
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        req0 = 1'b0;
        req1 = 1'b0;
        @(negedge clock);
        reset = 1'b0;
        ref_rd0  = '0;
        ref_rd1  = '0;
        ref_last = 1'b1;
    endtask

    task automatic set_port(input logic p);
        if (p) begin
            we1 = 1'($urandom); addr1 = 4'($urandom); wdata1 = $urandom;
        end else begin
            we0 = 1'($urandom); addr0 = 4'($urandom); wdata0 = $urandom;
        end
    endtask

    // Model effect of a completed access by port p, using the values it presented.
    task automatic apply_model(input logic p);
        if (p) begin
            if (we1) ref_mem[addr1] = wdata1; else ref_rd1 = ref_mem[addr1];
        end else begin
            if (we0) ref_mem[addr0] = wdata0; else ref_rd0 = ref_mem[addr0];
        end
        ref_last = p;
    endtask

    task automatic wait_ack(output int cyc, output logic a0, output logic a1,
                            output int nrd, output int nwr, output int nidle);
        cyc = 0; nrd = 0; nwr = 0; nidle = 0; a0 = 1'b0; a1 = 1'b0;
        while (cyc < 20 && !(a0 || a1)) begin
            @(negedge clock);
            cyc++;
            if (MemRead) nrd++;
            if (MemWrite) nwr++;
            if (!busy) nidle++;
            a0 = ack0;
            a1 = ack1;
        end
    endtask

    task automatic test_reset();
        int          cyc, nrd, nwr, nidle;
        logic        a0, a1;
        reset = 1'b1;
        req0 = 1'b1; we0 = 1'b0; addr0 = 4'h5; wdata0 = $urandom;
        @(negedge clock);
        n_vec++;
        if ({ack0, ack1, MemRead, MemWrite, mem_addr, mem_wdata, rdata0, rdata1, busy} !== '0) begin
            n_err++;
            $display("FAIL reset_outputs: got ack0=%0b ack1=%0b rd=%0b wr=%0b addr=%h rdata0=%h rdata1=%h busy=%0b, want all 0",
                     ack0, ack1, MemRead, MemWrite, mem_addr, rdata0, rdata1, busy);
        end
        reset = 1'b0;
        ref_rd0 = '0; ref_rd1 = '0; ref_last = 1'b1;
        @(negedge clock);
        n_vec++;
        if ({MemRead, MemWrite, mem_addr} !== {1'b1, 1'b0, 4'h5}) begin
            n_err++;
            $display("FAIL first_read_strobe: got rd=%0b wr=%0b addr=%h, want rd=1 wr=0 addr=5", MemRead, MemWrite, mem_addr);
        end
        @(negedge clock);
        apply_model(1'b0);
        n_vec++;
        if ({ack0, ack1, rdata0} !== {1'b1, 1'b0, ref_rd0}) begin
            n_err++;
            $display("FAIL first_read_ack: got ack0=%0b ack1=%0b rdata0=%h, want ack0=1 ack1=0 rdata0=%h", ack0, ack1, rdata0, ref_rd0);
        end
        req0 = 1'b0;
        @(negedge clock);
        n_vec++;
        if ({ack0, busy} !== 2'b00) begin
            n_err++;
            $display("FAIL ack_one_cycle: got ack0=%0b busy=%0b, want 0 0", ack0, busy);
        end
        wait_ack(cyc, a0, a1, nrd, nwr, nidle);
        n_vec++;
        if ({a0, a1, nrd, nwr} !== {2'b00, 32'd0, 32'd0}) begin
            n_err++;
            $display("FAIL no_spurious_access: got ack0=%0b ack1=%0b reads=%0d writes=%0d, want none", a0, a1, nrd, nwr);
        end
    endtask

    task automatic test_write_read();
        int   cyc, nrd, nwr, nidle;
        logic a0, a1;
        apply_reset();
        req0 = 1'b1; we0 = 1'b1; addr0 = 4'h3; wdata0 = 32'hDEADBEEF;
        wait_ack(cyc, a0, a1, nrd, nwr, nidle);
        apply_model(1'b0);
        req0 = 1'b0;
        n_vec++;
        if ({a0, a1, cyc, nrd, nwr} !== {2'b10, 32'd2, 32'd0, 32'd1}) begin
            n_err++;
            $display("FAIL write_p0: got ack0=%0b ack1=%0b cycle=%0d reads=%0d writes=%0d, want ack0 at 2 with 1 write",
                     a0, a1, cyc, nrd, nwr);
        end
        @(negedge clock);
        req1 = 1'b1; we1 = 1'b0; addr1 = 4'h3;
        wait_ack(cyc, a0, a1, nrd, nwr, nidle);
        apply_model(1'b1);
        req1 = 1'b0;
        n_vec++;
        if ({a0, a1, cyc, nrd, rdata1, rdata0} !== {2'b01, 32'd2, 32'd1, 32'hDEADBEEF, 32'd0}) begin
            n_err++;
            $display("FAIL read_back_p1: got ack1=%0b cycle=%0d reads=%0d rdata1=%h rdata0=%h, want ack1 at 2 rdata1=deadbeef rdata0=0",
                     a1, cyc, nrd, rdata1, rdata0);
        end
        @(negedge clock);
    endtask

    task automatic test_simultaneous();
        int   cyc, nrd, nwr, nidle;
        logic a0, a1;
        apply_reset();
        req0 = 1'b1; we0 = 1'b0; addr0 = 4'($urandom);
        req1 = 1'b1; we1 = 1'b0; addr1 = 4'($urandom);
        wait_ack(cyc, a0, a1, nrd, nwr, nidle);
        apply_model(1'b0);
        req0 = 1'b0;
        n_vec++;
        if ({a0, a1, cyc, rdata0} !== {2'b10, 32'd2, ref_rd0}) begin
            n_err++;
            $display("FAIL tie_first_p0: got ack0=%0b ack1=%0b cycle=%0d rdata0=%h, want ack0 at 2 rdata0=%h", a0, a1, cyc, rdata0, ref_rd0);
        end
        wait_ack(cyc, a0, a1, nrd, nwr, nidle);
        apply_model(1'b1);
        req1 = 1'b0;
        n_vec++;
        if ({a0, a1, cyc, rdata1} !== {2'b01, 32'd3, ref_rd1}) begin
            n_err++;
            $display("FAIL tie_second_p1: got ack0=%0b ack1=%0b cycle=%0d after first ack rdata1=%h, want ack1 3 later rdata1=%h",
                     a0, a1, cyc, rdata1, ref_rd1);
        end
        @(negedge clock);
    endtask

    task automatic test_round_robin();
        int   cyc, nrd, nwr, nidle;
        logic a0, a1, exp_p, got_p, exp_we;
        set_port(1'b0);
        set_port(1'b1);
        req0 = 1'b1;
        req1 = 1'b1;
        for (int k = 0; k < 6; k++) begin
            exp_p  = ~ref_last;
            exp_we = exp_p ? we1 : we0;
            wait_ack(cyc, a0, a1, nrd, nwr, nidle);
            got_p = a1;
            apply_model(exp_p);
            n_vec++;
            if ({a0, a1, cyc, nidle, nrd, nwr, rdata0, rdata1} !==
                {~exp_p, exp_p, 32'd2, 32'd0, 32'(!exp_we), 32'(exp_we), ref_rd0, ref_rd1}) begin
                n_err++;
                $display("FAIL round_robin_%0d: got ack0=%0b ack1=%0b cycle=%0d idle=%0d rd=%0d wr=%0d rdata0=%h rdata1=%h, want port %0d at 2 rdata0=%h rdata1=%h",
                         k, a0, a1, cyc, nidle, nrd, nwr, rdata0, rdata1, exp_p, ref_rd0, ref_rd1);
            end
            if (got_p) req1 = 1'b0; else req0 = 1'b0;
            if (k == 5) begin
                req0 = 1'b0;
                req1 = 1'b0;
            end
            @(negedge clock);
            n_vec++;
            if ({busy, ack0, ack1} !== 3'b000) begin
                n_err++;
                $display("FAIL rr_gap_%0d: got busy=%0b ack0=%0b ack1=%0b, want all 0", k, busy, ack0, ack1);
            end
            if (k != 5) begin
                set_port(exp_p);
                if (exp_p) req1 = 1'b1; else req0 = 1'b1;
            end
        end
    endtask

    task automatic test_random();
        int   cyc, nrd, nwr, nidle, r, n_acc;
        logic a0, a1, exp_p, exp_we;
        for (int round = 0; round < 16; round++) begin
            r = int'($urandom_range(0, 3));
            set_port(1'b0);
            set_port(1'b1);
            req0 = r[0];
            req1 = r[1];
            if (r == 0) begin
                repeat (3) @(negedge clock);
                n_vec++;
                if ({busy, MemRead, MemWrite, ack0, ack1} !== 5'b0) begin
                    n_err++;
                    $display("FAIL idle_no_req_%0d: got busy=%0b rd=%0b wr=%0b, want idle", round, busy, MemRead, MemWrite);
                end
            end else begin
                n_acc = (r == 3) ? 2 : 1;
                exp_p = (r == 3) ? ~ref_last : r[1];
                for (int k = 0; k < n_acc; k++) begin
                    exp_we = exp_p ? we1 : we0;
                    wait_ack(cyc, a0, a1, nrd, nwr, nidle);
                    apply_model(exp_p);
                    n_vec++;
                    if ({a0, a1, cyc, nrd, nwr, rdata0, rdata1} !==
                        {~exp_p, exp_p, 32'(2 + k), 32'(!exp_we), 32'(exp_we), ref_rd0, ref_rd1}) begin
                        n_err++;
                        $display("FAIL random_%0d_%0d: got ack0=%0b ack1=%0b cycle=%0d rd=%0d wr=%0d rdata0=%h rdata1=%h, want port %0d at %0d rdata0=%h rdata1=%h",
                                 round, k, a0, a1, cyc, nrd, nwr, rdata0, rdata1, exp_p, 2 + k, ref_rd0, ref_rd1);
                    end
                    if (exp_p) req1 = 1'b0; else req0 = 1'b0;
                    exp_p = ~exp_p;
                end
                @(negedge clock);
            end
        end
    endtask

    task automatic test_reset_abort();
        int          cyc, nrd, nwr, nidle, seen_ack;
        logic        a0, a1;
        logic [31:0] old7;
        old7 = ref_mem[7];
        req1 = 1'b1; we1 = 1'b1; addr1 = 4'h7; wdata1 = ~old7;
        @(negedge clock);
        n_vec++;
        if ({MemWrite, mem_addr} !== {1'b1, 4'h7}) begin
            n_err++;
            $display("FAIL abort_in_access: got wr=%0b addr=%h, want wr=1 addr=7", MemWrite, mem_addr);
        end
        #2 reset = 1'b1;
        #1;
        n_vec++;
        if ({MemWrite, busy} !== 2'b00) begin
            n_err++;
            $display("FAIL abort_async_drop: got wr=%0b busy=%0b, want 0 0 before next edge", MemWrite, busy);
        end
        req1 = 1'b0;
        seen_ack = 0;
        repeat (3) begin
            @(negedge clock);
            if (ack0 || ack1) seen_ack++;
        end
        reset = 1'b0;
        ref_rd0 = '0; ref_rd1 = '0; ref_last = 1'b1;
        repeat (2) begin
            @(negedge clock);
            if (ack0 || ack1) seen_ack++;
        end
        n_vec++;
        if ({seen_ack, busy} !== {32'd0, 1'b0}) begin
            n_err++;
            $display("FAIL abort_no_ack: got %0d ack cycles busy=%0b, want 0 0", seen_ack, busy);
        end
        req0 = 1'b1; we0 = 1'b0; addr0 = 4'h7;
        req1 = 1'b1; we1 = 1'b0; addr1 = 4'($urandom);
        wait_ack(cyc, a0, a1, nrd, nwr, nidle);
        apply_model(1'b0);
        req0 = 1'b0;
        n_vec++;
        if ({a0, a1, cyc, rdata0} !== {2'b10, 32'd2, old7}) begin
            n_err++;
            $display("FAIL abort_after_release: got ack0=%0b ack1=%0b cycle=%0d rdata0=%h, want ack0 at 2 rdata0=%h (unwritten)",
                     a0, a1, cyc, rdata0, old7);
        end
        wait_ack(cyc, a0, a1, nrd, nwr, nidle);
        apply_model(1'b1);
        req1 = 1'b0;
        n_vec++;
        if ({a1, cyc, rdata1} !== {1'b1, 32'd3, ref_rd1}) begin
            n_err++;
            $display("FAIL abort_then_p1: got ack1=%0b cycle=%0d rdata1=%h, want ack1 at 3 rdata1=%h", a1, cyc, rdata1, ref_rd1);
        end
        @(negedge clock);
    endtask

    task automatic test_latency3();
        logic [31:0] va, vb, vc;
        va = $urandom; vb = va ^ 32'h1; vc = va ^ 32'h2;
        req0_l3 = 1'b1; we0_l3 = 1'b0; addr0_l3 = 4'h9; mem_rdata_l3 = va;
        @(negedge clock);
        n_vec++;
        if ({mem_read_l3, mem_addr_l3, ack0_l3} !== {1'b1, 4'h9, 1'b0}) begin
            n_err++;
            $display("FAIL lat3_cycle1: got rd=%0b addr=%h ack0=%0b, want rd=1 addr=9 ack0=0", mem_read_l3, mem_addr_l3, ack0_l3);
        end
        mem_rdata_l3 = vb;
        @(negedge clock);
        req0_l3 = 1'b0;
        mem_rdata_l3 = vc;
        n_vec++;
        if ({mem_read_l3, ack0_l3} !== 2'b10) begin
            n_err++;
            $display("FAIL lat3_cycle2: got rd=%0b ack0=%0b, want 1 0", mem_read_l3, ack0_l3);
        end
        @(negedge clock);
        n_vec++;
        if ({mem_read_l3, ack0_l3} !== 2'b10) begin
            n_err++;
            $display("FAIL lat3_cycle3: got rd=%0b ack0=%0b, want 1 0 despite req drop", mem_read_l3, ack0_l3);
        end
        @(negedge clock);
        n_vec++;
        if ({ack0_l3, ack1_l3, mem_read_l3, mem_write_l3, rdata0_l3} !== {4'b1000, vc}) begin
            n_err++;
            $display("FAIL lat3_ack: got ack0=%0b ack1=%0b rd=%0b wr=%0b rdata0=%h, want ack0 only rdata0=%h",
                     ack0_l3, ack1_l3, mem_read_l3, mem_write_l3, rdata0_l3, vc);
        end
        @(negedge clock);
        @(negedge clock);
        n_vec++;
        if ({ack0_l3, mem_read_l3, busy_l3} !== 3'b000) begin
            n_err++;
            $display("FAIL lat3_done: got ack0=%0b rd=%0b busy=%0b, want idle", ack0_l3, mem_read_l3, busy_l3);
        end
    endtask

    initial begin
        fill_mem();
        test_reset();
        test_write_read();
        test_simultaneous();
        test_round_robin();
        test_random();
        test_reset_abort();
        test_latency3();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion by 200000, want finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
